unified_memory_arbiter: RTL and testbench

//  Shares one single-port, variable-latency memory between the instruction-fetch port and the load/store port of the MIPS core.

---
 rtl/unified_memory_arbiter_pkg.sv | 20 ++
 rtl/unified_memory_arbiter_if.sv | 43 ++++
 rtl/unified_memory_arbiter_timeout_counter.sv | 34 +++
 rtl/unified_memory_arbiter.sv | 125 ++++++++++++
 tb/tb_unified_memory_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_memory_arbiter_pkg.sv
// Shared types and widths for the fetch / load-store memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   // Wide enough for the largest allowed starvation limit (15).
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT_IF = 2'd1,
      GRANT_D  = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

endpackage

// File: rtl/unified_memory_arbiter_if.sv
// Core-side fetch/data ports and memory-side bus of the unified memory arbiter.
interface unified_memory_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  if_req_i;
   logic [ADDR_WIDTH-1:0] if_addr_i;
   logic [DATA_WIDTH-1:0] if_rdata_o;
   logic                  if_valid_o;
   logic                  if_stall_o;

   logic                  d_req_i;
   logic                  d_we_i;
   logic [ADDR_WIDTH-1:0] d_addr_i;
   logic [DATA_WIDTH-1:0] d_wdata_i;
   logic [DATA_WIDTH-1:0] d_rdata_o;
   logic                  d_valid_o;
   logic                  d_stall_o;

   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
   logic                  mem_ack_i;

   logic                  err_o;

   modport slave (
      input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
             mem_rdata_i, mem_ack_i,
      output if_rdata_o, if_valid_o, if_stall_o, d_rdata_o, d_valid_o, d_stall_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
   );

   modport master (
      output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
             mem_rdata_i, mem_ack_i,
      input  if_rdata_o, if_valid_o, if_stall_o, d_rdata_o, d_valid_o, d_stall_o,
             mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
   );

endinterface

// File: rtl/unified_memory_arbiter_timeout_counter.sv
// Ack timeout counter: load arms and zeroes it, clear disarms, expire marks the last allowed cycle.
module arb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic clear,
   output logic expire
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             armed;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (load) begin
         cnt   <= '0;
         armed <= 1'b1;
      end else if (clear) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (armed) begin
         cnt   <= cnt + 1'b1;
      end
   end

   // cnt counts completed request cycles, so the TIMEOUT_CYCLES-th cycle sees TIMEOUT_CYCLES-1.
   assign expire = armed && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/unified_memory_arbiter.sv
// Shares one single-port memory between fetch and load/store; data wins unless fetch has starved.
// Build option MEM_TIMEOUT_EN: abort an unacknowledged access after TIMEOUT_CYCLES and pulse err_o.
module unified_memory_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_W,
   parameter int DATA_WIDTH     = DATA_W,
   parameter int MAX_WAIT       = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                     clk,
   input logic                     reset,
   unified_memory_arbiter_if.slave bus
);

   state_e                  state_q, state_d;
   owner_e                  owner;
   logic                    grant_if, grant_d, done, expired, timed_out;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q;
   logic                    mem_req_q, mem_we_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, if_rdata_q, d_rdata_q, done_rdata;
   logic                    if_valid_q, d_valid_q, err_q;

   always_comb begin
      state_d  = state_q;
      grant_if = 1'b0;
      grant_d  = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.if_req_i && (!bus.d_req_i || wait_cnt_q == WAIT_CNT_W'(MAX_WAIT))) begin
               grant_if = 1'b1;
               state_d  = GRANT_IF;
            end else if (bus.d_req_i) begin
               grant_d  = 1'b1;
               state_d  = GRANT_D;
            end
         end
         GRANT_IF, GRANT_D: begin
            if (bus.mem_ack_i || expired) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An ack arriving in the expiry cycle still counts as a normal completion.
   assign timed_out  = expired && !bus.mem_ack_i;
   assign done_rdata = timed_out ? '0 : bus.mem_rdata_i;
   assign owner      = (state_q == GRANT_D) ? OWN_D : OWN_IF;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         err_q      <= 1'b0;
         if (grant_if || grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= grant_d && bus.d_we_i;
            mem_addr_q  <= grant_d ? bus.d_addr_i : bus.if_addr_i;
            mem_wdata_q <= grant_d ? bus.d_wdata_i : '0;
         end else if (done) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            err_q     <= timed_out;
            if (owner == OWN_D) begin
               d_rdata_q <= mem_we_q ? '0 : done_rdata;
               d_valid_q <= 1'b1;
            end else begin
               if_rdata_q <= done_rdata;
               if_valid_q <= 1'b1;
            end
         end
         // Count data grants that a waiting fetch lost; a fetch grant forgives them.
         if (grant_if)
            wait_cnt_q <= '0;
         else if (grant_d && bus.if_req_i && wait_cnt_q != WAIT_CNT_W'(MAX_WAIT))
            wait_cnt_q <= wait_cnt_q + 1'b1;
      end
   end

`ifdef MEM_TIMEOUT_EN
   arb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .load   (grant_if || grant_d),
      .clear  (done),
      .expire (expired)
   );
`else
   // Without the counter only a degenerate zero-cycle timeout could ever fire.
   assign expired = (TIMEOUT_CYCLES < 1);
`endif

   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.if_valid_o  = if_valid_q;
   assign bus.if_stall_o  = bus.if_req_i && !if_valid_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.d_valid_o   = d_valid_q;
   assign bus.d_stall_o   = bus.d_req_i && !d_valid_q;
   assign bus.err_o       = err_q;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Randomized bench for unified_memory_arbiter against a cycle-level behavioural model.
module tb_unified_memory_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int TMO      = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   unified_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   unified_memory_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0, bad = 0, cyc = 0;

   // model: the access in flight and what the next cycle must show
   logic        exp_req = 0, exp_ifv = 0, exp_dv = 0, exp_err = 0;
   logic [31:0] exp_ifr = 0, exp_dr = 0;
   logic        acc_d = 0, acc_we = 0;
   logic [31:0] acc_addr = 0, acc_wd = 0;
   int          lat_left = 0, age = 0, losses = 0;

   // stimulus knobs
   int          p_if = 0, p_d = 0, lat_max = 3, lat_force = -1;
   logic        rd_fix_en = 0;
   logic [31:0] rd_fix = 0;
   logic        dir_if = 0, dir_d = 0, dir_d_we = 0;
   logic [31:0] dir_if_addr = 0, dir_d_addr = 0, dir_d_wd = 0;
   int          n_ifv = 0, n_dv = 0, t_ifv = 0, t_dv = 0, t_ifreq = 0, t_dreq = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic finish_acc(input logic [31:0] val, input logic e);
      exp_req = 0;
      exp_err = e;
      if (acc_d) begin
         exp_dv = 1;
         exp_dr = acc_we ? 32'h0 : val;
      end else begin
         exp_ifv = 1;
         exp_ifr = val;
      end
   endtask

   task automatic step();
      logic sifv, sdv, fetch_win;
      @(posedge clk); #1;
      cyc++;
      chk("mem_req", bus.mem_req_o, exp_req);
      if (exp_req) begin
         chk("mem_addr", bus.mem_addr_o, acc_addr);
         chk("mem_we", bus.mem_we_o, acc_we);
         if (acc_we) chk("mem_wdata", bus.mem_wdata_o, acc_wd);
      end
      chk("if_valid", bus.if_valid_o, exp_ifv);
      chk("d_valid", bus.d_valid_o, exp_dv);
      chk("err", bus.err_o, exp_err);
      if (exp_ifv) chk("if_rdata", bus.if_rdata_o, exp_ifr);
      if (exp_dv)  chk("d_rdata", bus.d_rdata_o, exp_dr);
      sifv = exp_ifv;
      sdv  = exp_dv;
      // requesters: drop on completion, then maybe issue a new one at once
      if (sifv) begin n_ifv++; t_ifv = cyc; bus.if_req_i = 0; end
      if (sdv)  begin n_dv++;  t_dv  = cyc; bus.d_req_i  = 0; end
      if (!bus.if_req_i && (dir_if || $urandom_range(99) < p_if)) begin
         bus.if_req_i  = 1;
         bus.if_addr_i = dir_if ? dir_if_addr : ($urandom & 32'hFFFF_FFFC);
         dir_if  = 0;
         t_ifreq = cyc;
      end
      if (!bus.d_req_i && (dir_d || $urandom_range(99) < p_d)) begin
         bus.d_req_i   = 1;
         bus.d_we_i    = dir_d ? dir_d_we : 1'($urandom_range(1));
         bus.d_addr_i  = dir_d ? dir_d_addr : ($urandom & 32'hFFFF_FFFC);
         bus.d_wdata_i = dir_d ? dir_d_wd : $urandom;
         dir_d  = 0;
         t_dreq = cyc;
      end
      // memory and arbitration rules
      exp_ifv = 0; exp_dv = 0; exp_err = 0;
      bus.mem_ack_i   = 0;
      bus.mem_rdata_i = $urandom;
      if (exp_req) begin
         age++;
         if (lat_left == 0) begin
            if (rd_fix_en) bus.mem_rdata_i = rd_fix;
            bus.mem_ack_i = 1;
            finish_acc(bus.mem_rdata_i, 1'b0);
         end else begin
            lat_left--;
`ifdef MEM_TIMEOUT_EN
            if (age == TMO) finish_acc(32'h0, 1'b1);
`endif
         end
      end else if (bus.if_req_i || bus.d_req_i) begin
         fetch_win = bus.if_req_i && (!bus.d_req_i || losses == MAX_WAIT);
         if (fetch_win) begin
            acc_d = 0; acc_we = 0; acc_addr = bus.if_addr_i; acc_wd = 0;
            losses = 0;
         end else begin
            acc_d = 1; acc_we = bus.d_we_i; acc_addr = bus.d_addr_i; acc_wd = bus.d_wdata_i;
            if (bus.if_req_i && losses < MAX_WAIT) losses++;
         end
         exp_req  = 1;
         age      = 0;
         lat_left = (lat_force >= 0) ? lat_force : $urandom_range(lat_max);
      end
      #1;
      chk("if_stall", bus.if_stall_o, bus.if_req_i && !sifv);
      chk("d_stall", bus.d_stall_o, bus.d_req_i && !sdv);
   endtask

   task automatic quiesce();
      int b = 100;
      p_if = 0; p_d = 0;
      while ((bus.if_req_i || bus.d_req_i || exp_req || exp_ifv || exp_dv) && b > 0) begin
         step(); b--;
      end
      if (bus.if_req_i || bus.d_req_i || exp_req) chk("quiesce", 32'd0, 32'd1);
   endtask

   task automatic wait_ifv(input int target, input int budget);
      int b = budget;
      while (n_ifv < target && b > 0) begin step(); b--; end
      if (n_ifv < target) chk("wait_ifv", n_ifv, target);
   endtask

   task automatic wait_dv(input int target, input int budget);
      int b = budget;
      while (n_dv < target && b > 0) begin step(); b--; end
      if (n_dv < target) chk("wait_dv", n_dv, target);
   endtask

   initial begin
      int dv0, prev_dv;
      bus.if_req_i = 0; bus.if_addr_i = 0;
      bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = 0; bus.d_wdata_i = 0;
      bus.mem_rdata_i = 0; bus.mem_ack_i = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", bus.mem_req_o, 0);
      chk("rst_mem_we", bus.mem_we_o, 0);
      chk("rst_mem_addr", bus.mem_addr_o, 0);
      chk("rst_mem_wdata", bus.mem_wdata_o, 0);
      chk("rst_if_valid", bus.if_valid_o, 0);
      chk("rst_d_valid", bus.d_valid_o, 0);
      chk("rst_if_rdata", bus.if_rdata_o, 0);
      chk("rst_d_rdata", bus.d_rdata_o, 0);
      chk("rst_err", bus.err_o, 0);
      reset = 0;

      // fetch only, two wait states
      lat_force = 2; rd_fix_en = 1; rd_fix = 32'h2008_0005;
      dir_if = 1; dir_if_addr = 32'h0040_0000;
      wait_ifv(n_ifv + 1, 20);
      chk("fetch_lat", t_ifv - t_ifreq, 4);
      chk("fetch_rdata", bus.if_rdata_o, 32'h2008_0005);
      rd_fix_en = 0; lat_force = -1;

      // store
      quiesce();
      lat_force = 1;
      dir_d = 1; dir_d_we = 1; dir_d_addr = 32'h1001_0004; dir_d_wd = 32'hDEAD_BEEF;
      step(); step();
      chk("st_we", bus.mem_we_o, 1);
      chk("st_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
      wait_dv(n_dv + 1, 20);
      chk("st_rdata", bus.d_rdata_o, 0);
      lat_force = -1;

      // simultaneous fetch and load
      quiesce();
      dv0 = n_dv;
      dir_if = 1; dir_if_addr = 32'h0040_0004;
      dir_d = 1; dir_d_we = 0; dir_d_addr = 32'h1001_0000;
      step(); step();
      chk("sim_first", bus.mem_addr_o, 32'h1001_0000);
      wait_ifv(n_ifv + 1, 40);
      chk("sim_d_done", n_dv, dv0 + 1);
      chk("sim_order", t_dv < t_ifv, 1);

      // starvation guard: continuous data traffic with a fetch always pending
      quiesce();
      p_if = 100; p_d = 100;
      prev_dv = n_dv;
      for (int r = 0; r < 3; r++) begin
         wait_ifv(n_ifv + 1, 80);
         chk("starve_d_grants", n_dv - prev_dv, MAX_WAIT);
         prev_dv = n_dv;
      end

      // random traffic
      quiesce();
      p_if = 35; p_d = 50;
      repeat (500) step();

      // reset one cycle into a data grant
      quiesce();
      lat_force = 6;
      dir_d = 1; dir_d_we = 0; dir_d_addr = 32'h1001_0008;
      step(); step();
      reset = 1;
      #1;
      chk("rstmid_mem_req", bus.mem_req_o, 0);
      chk("rstmid_d_valid", bus.d_valid_o, 0);
      @(posedge clk); #1;
      bus.d_req_i = 0; bus.mem_ack_i = 0;
      reset = 0;
      exp_req = 0; exp_ifv = 0; exp_dv = 0; exp_err = 0; losses = 0; lat_force = -1;
      dv0 = n_dv;
      repeat (8) step();
      chk("rstmid_no_dv", n_dv, dv0);
      dir_if = 1; dir_if_addr = 32'h0040_0010;
      wait_ifv(n_ifv + 1, 20);

`ifdef MEM_TIMEOUT_EN
      quiesce();
      lat_force = 1000;
      dir_d = 1; dir_d_we = 0; dir_d_addr = 32'h1001_000C;
      wait_dv(n_dv + 1, 40);
      chk("tmo_lat", t_dv - t_dreq, TMO + 1);
      chk("tmo_rdata", bus.d_rdata_o, 0);
      chk("tmo_err", bus.err_o, 1);
      lat_force = -1;
`endif

      quiesce();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
